result_bcd: RTL and testbench

RESULT_BCD -- requirements
Module: result_bcd

---
 rtl/calc_pkg.sv | 29 ++
 rtl/bcd_digit_adj.sv | 17 +
 rtl/result_bcd.sv | 167 ++++++++++++++++
 tb/tb_result_bcd.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// ============================================================================
// Module      : calc_pkg
// Description : Shared calculator constants, BCD FSM state type and sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

    localparam int RESULT_W   = 21;
    localparam int BCD_DIGITS = 6;
    localparam int BCD_MAX    = 999999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } bcd_state_e;

    // floor(w*log10(2))+1 digits hold any w-bit magnitude; never fewer than ndig
    function automatic int acc_digits(input int w, input int ndig);
        int n;
        n = (w * 30103) / 100000 + 1;
        return (n > ndig) ? n : ndig;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
// Module      : bcd_digit_adj
// Description : Double-dabble digit correction, adds 3 to a BCD digit >= 5.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;

endmodule

`default_nettype wire

// File: rtl/result_bcd.sv
// ============================================================================
// Module      : result_bcd
// Description : Sequential signed binary to BCD converter (double dabble) with
//               range/overflow error and optional leading-zero blanking
//               (enabled by defining RESULT_BCD_BLANK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_bcd
    import calc_pkg::*;
#(
    parameter int W    = RESULT_W,
    parameter int NDIG = BCD_DIGITS
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [W-1:0]      value,
    input  logic              ovf_in,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] digits,
    output logic              sign,
    output logic              err,
    output logic [NDIG-1:0]   blank
);

    localparam int ACC = acc_digits(W, NDIG);
    localparam int CW  = $clog2(W + 1);

    bcd_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W-1:0]      mag_q, mag_d;
    logic [4*ACC-1:0]  acc_q, acc_d, acc_adj;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;
    logic              lost_q, lost_d;
    logic              done_q, done_d;
    logic [4*NDIG-1:0] digits_q, digits_d;
    logic              sign_q, sign_d;
    logic              err_q, err_d;
    logic              over_range;
    logic [4*NDIG-1:0] fin_digits;

    for (genvar g = 0; g < ACC; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (acc_q[4*g +: 4]),
            .d_o (acc_adj[4*g +: 4])
        );
    end

    always_comb begin
        over_range = ovf_q | lost_q;
        for (int i = NDIG; i < ACC; i++) begin
            if (acc_q[4*i +: 4] != 4'd0) over_range = 1'b1;
        end
        fin_digits = over_range ? '0 : acc_q[4*NDIG-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mag_d    = mag_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        lost_d   = lost_q;
        done_d   = 1'b0;
        digits_d = digits_q;
        sign_d   = sign_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    neg_d   = value[W-1];
                    // -2^(W-1) negates to itself, which read unsigned is the true magnitude
                    mag_d   = value[W-1] ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;
                    ovf_d   = ovf_in;
                    lost_d  = 1'b0;
                    acc_d   = '0;
                    cnt_d   = CW'(W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d  = {acc_adj[4*ACC-2:0], mag_q[W-1]};
                mag_d  = {mag_q[W-2:0], 1'b0};
                lost_d = lost_q | acc_adj[4*ACC-1];
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FINISH;
            end
            FINISH: begin
                digits_d = fin_digits;
                sign_d   = neg_q;
                err_d    = over_range;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mag_q    <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            lost_q   <= 1'b0;
            done_q   <= 1'b0;
            digits_q <= '0;
            sign_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mag_q    <= mag_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            lost_q   <= lost_d;
            done_q   <= done_d;
            digits_q <= digits_d;
            sign_q   <= sign_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign digits = digits_q;
    assign sign   = sign_q;
    assign err    = err_q;

`ifdef RESULT_BCD_BLANK_EN
    logic [NDIG-1:0] blank_q, blank_d;

    // Digit 0 always shows, so zero displays as "0"
    always_comb begin : p_blank
        logic z;
        z       = 1'b1;
        blank_d = '0;
        for (int i = NDIG - 1; i >= 1; i--) begin
            z          = z & (fin_digits[4*i +: 4] == 4'd0);
            blank_d[i] = z;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blank_q <= '0;
        end else if (state_q == FINISH) begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_result_bcd.sv
// ============================================================================
// Module      : tb_result_bcd
// Description : Scoreboard testbench for result_bcd (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_bcd;

    localparam int W    = 21;
    localparam int NDIG = 6;
    localparam int LAT  = 22;

    logic              clock;
    logic              reset_n;
    logic              start;
    logic [W-1:0]      value;
    logic              ovf_in;
    logic              busy;
    logic              done;
    logic [4*NDIG-1:0] digits;
    logic              sign;
    logic              err;
    logic [NDIG-1:0]   blank;

    result_bcd #(.W(W), .NDIG(NDIG)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .value   (value),
        .ovf_in  (ovf_in),
        .busy    (busy),
        .done    (done),
        .digits  (digits),
        .sign    (sign),
        .err     (err),
        .blank   (blank)
    );

    typedef struct {
        logic [23:0] d;
        logic        s;
        logic        e;
        logic [5:0]  b;
        int          c;
    } exp_t;

    typedef struct {
        logic [W-1:0] v;
        logic         ov;
        logic [23:0]  d;
        logic         s;
        logic         e;
        logic [5:0]   b;
    } vec_t;

    exp_t q[$];
    exp_t hold;
    vec_t vecs[11];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] blank_exp(input logic [5:0] b);
`ifdef RESULT_BCD_BLANK_EN
        return b;
`else
        return (b & 6'b0);
`endif
    endfunction

    // Monitor: pops one expectation per done pulse, otherwise outputs must hold
    always @(negedge clock) begin
        if (reset_n) begin
            if (done) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.c));
                    check("digits", 64'(digits), 64'(e.d));
                    check("sign", 64'(sign), 64'(e.s));
                    check("err", 64'(err), 64'(e.e));
                    check("blank", 64'(blank), 64'(e.b));
                    check("busy_at_done", 64'(busy), 64'(0));
                    hold = e;
                end
            end else begin
                check("hold_outputs", 64'({digits, sign, err, blank}),
                      64'({hold.d, hold.s, hold.e, hold.b}));
            end
        end
    end

    task automatic issue(input vec_t v, input bit push);
        exp_t e;
        value  = v.v;
        ovf_in = v.ov;
        start  = 1'b1;
        @(posedge clock);
        #1;
        e.d = v.d; e.s = v.s; e.e = v.e; e.b = blank_exp(v.b); e.c = cyc + LAT;
        if (push) q.push_back(e);
        start  = 1'b0;
        value  = W'($urandom);
        ovf_in = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while (busy && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=1 expected 0 within 60 cycles");
        end
    endtask

    initial begin
        vec_t tmp;
        int   n;
        vecs[0]  = '{21'd998001,        1'b0, 24'h998001, 1'b0, 1'b0, 6'b000000};
        vecs[1]  = '{21'(-998001),      1'b0, 24'h998001, 1'b1, 1'b0, 6'b000000};
        vecs[2]  = '{21'd0,             1'b0, 24'h000000, 1'b0, 1'b0, 6'b111110};
        vecs[3]  = '{21'h100000,        1'b0, 24'h000000, 1'b1, 1'b1, 6'b111110};
        vecs[4]  = '{21'd5,             1'b1, 24'h000000, 1'b0, 1'b1, 6'b111110};
        vecs[5]  = '{21'd42,            1'b0, 24'h000042, 1'b0, 1'b0, 6'b111100};
        vecs[6]  = '{21'd999999,        1'b0, 24'h999999, 1'b0, 1'b0, 6'b000000};
        vecs[7]  = '{21'd1000000,       1'b0, 24'h000000, 1'b0, 1'b1, 6'b111110};
        vecs[8]  = '{21'h1FFFFF,        1'b0, 24'h000001, 1'b1, 1'b0, 6'b111110};
        vecs[9]  = '{21'd1048575,       1'b0, 24'h000000, 1'b0, 1'b1, 6'b111110};
        vecs[10] = '{21'd100,           1'b0, 24'h000100, 1'b0, 1'b0, 6'b111000};

        hold    = '{24'h0, 1'b0, 1'b0, 6'b0, 0};
        reset_n = 1'b1;
        start   = 1'b0;
        value   = '0;
        ovf_in  = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_digits", 64'(digits), 64'(0));
        check("rst_sign", 64'(sign), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_blank", 64'(blank), 64'(0));

        // Release reset and start on the very first edge
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        issue(vecs[0], 1'b1);

        // Each wait_idle lands in the done cycle, so these run back-to-back
        for (int i = 1; i < 11; i++) begin
            wait_idle();
            issue(vecs[i], 1'b1);
        end

        // Start re-pulsed with a new value while busy must be ignored
        wait_idle();
        tmp = '{21'd123, 1'b0, 24'h000123, 1'b0, 1'b0, 6'b111000};
        issue(tmp, 1'b1);
        repeat (4) @(posedge clock);
        @(negedge clock);
        value  = 21'd777;
        ovf_in = 1'b1;
        start  = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        check("busy_mid_conv", 64'(busy), 64'(1));

        // Reset in the middle of a conversion: no pulse may follow
        wait_idle();
        tmp = '{21'd654321, 1'b0, 24'h654321, 1'b0, 1'b0, 6'b000000};
        issue(tmp, 1'b0);
        repeat (9) @(posedge clock);
        #2 reset_n = 1'b0;
        hold = '{24'h0, 1'b0, 1'b0, 6'b0, 0};
        #1;
        check("async_rst_busy", 64'(busy), 64'(0));
        check("async_rst_done", 64'(done), 64'(0));
        check("async_rst_digits", 64'(digits), 64'(0));
        check("async_rst_sign", 64'(sign), 64'(0));
        check("async_rst_err", 64'(err), 64'(0));
        repeat (30) @(negedge clock);
        reset_n = 1'b1;
        issue(vecs[5], 1'b1);

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        repeat (5) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
